// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use / ID-branch stalls, mispredict flush, cache freeze.
// Latency: control outputs are combinational from the ID/EX/MEM fields (same cycle); FSM state registers on clk.
// Backpressure: cache stall freezes every stage and preserves the stall context; optional perf counters under HAZARD_PERF_EN.
module hazard_ctrl #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] iRs_RegD,
    input  logic [REG_AW-1:0] iRt_RegD,
    input  logic              iUseRs_RegD,
    input  logic              iUseRt_RegD,
    input  logic              iBranch_RegD,
    input  logic              iMispredict_RegD,
    input  logic              iRegWrite_RegE,
    input  logic              iMemRead_RegE,
    input  logic [REG_AW-1:0] iwsel_RegE,
    input  logic              iMemRead_RegM,
    input  logic [REG_AW-1:0] iwsel_RegM,
    input  logic              iICacheStall,
    input  logic              iDCacheStall,
    input  logic              iPerfClr,
    output logic              oPC_Hold,
    output logic              oIFID_Hold,
    output logic              oIDEX_Bubble,
    output logic              oIFID_Flush,
    output logic              oPipe_Freeze,
    output logic [1:0]        oState,
    output logic [CNT_W-1:0]  oStallCnt,
    output logic [CNT_W-1:0]  oFlushCnt,
    output logic [CNT_W-1:0]  oFreezeCnt
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_STALL  = 2'd1,
        ST_FREEZE = 2'd2
    } state_e;

    state_e     state_q, state_d;
    state_e     sv_state_q, sv_state_d;
    state_e     eff_state;
    logic [1:0] cnt_q, cnt_d;
    logic [1:0] sv_cnt_q, sv_cnt_d;
    logic [1:0] eff_cnt;

    logic match_e, match_m;
    logic need2, need1;
    logic freeze_req;
    logic stall_cyc, freeze_cyc;

    // Register $0 is never a real producer, so it can never cause a hazard.
    assign match_e = ((iUseRs_RegD && (iRs_RegD == iwsel_RegE)) ||
                      (iUseRt_RegD && (iRt_RegD == iwsel_RegE))) &&
                     (iwsel_RegE != '0);
    assign match_m = ((iUseRs_RegD && (iRs_RegD == iwsel_RegM)) ||
                      (iUseRt_RegD && (iRt_RegD == iwsel_RegM))) &&
                     (iwsel_RegM != '0);

    // Branch needing a loaded value still in EX waits two cycles; the other cases wait one.
    assign need2 = iBranch_RegD && iMemRead_RegE && match_e;
    assign need1 = (iMemRead_RegE && match_e) ||
                   (iBranch_RegD && iRegWrite_RegE && match_e) ||
                   (iBranch_RegD && iMemRead_RegM && match_m);

    assign freeze_req = iICacheStall || iDCacheStall;

    // Next-state and stall/freeze decision; FREEZE acts as the saved state once the caches are ready.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sv_state_d = sv_state_q;
        sv_cnt_d   = sv_cnt_q;
        stall_cyc  = 1'b0;
        freeze_cyc = 1'b0;
        eff_state  = (state_q == ST_FREEZE) ? sv_state_q : state_q;
        eff_cnt    = (state_q == ST_FREEZE) ? sv_cnt_q   : cnt_q;

        if (freeze_req) begin
            freeze_cyc = 1'b1;
            state_d    = ST_FREEZE;
            sv_state_d = eff_state;
            sv_cnt_d   = eff_cnt;
            cnt_d      = eff_cnt;
        end else begin
            case (eff_state)
                ST_STALL: begin
                    // Inputs are not re-examined; just count down the committed stall.
                    stall_cyc = 1'b1;
                    cnt_d     = eff_cnt - 2'd1;
                    state_d   = (eff_cnt <= 2'd1) ? ST_RUN : ST_STALL;
                end
                default: begin
                    cnt_d   = 2'd0;
                    state_d = ST_RUN;
                    if (need2) begin
                        stall_cyc = 1'b1;
                        state_d   = ST_STALL;
                        cnt_d     = 2'd1;
                    end else if (need1) begin
                        stall_cyc = 1'b1;
                    end
                end
            endcase
        end
    end

    // FSM state, remaining stall count and the context saved across a freeze.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_RUN;
            cnt_q      <= 2'd0;
            sv_state_q <= ST_RUN;
            sv_cnt_q   <= 2'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sv_state_q <= sv_state_d;
            sv_cnt_q   <= sv_cnt_d;
        end
    end

    // Outputs are forced low while reset is held; freeze > stall > flush.
    assign oPC_Hold     = rst_n && (stall_cyc || freeze_cyc);
    assign oIFID_Hold   = rst_n && (stall_cyc || freeze_cyc);
    assign oIDEX_Bubble = rst_n && stall_cyc;
    assign oPipe_Freeze = rst_n && freeze_cyc;
    assign oIFID_Flush  = rst_n && iMispredict_RegD && !stall_cyc && !freeze_cyc;
    assign oState       = state_q;

`ifdef HAZARD_PERF_EN
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q, freeze_cnt_q;

    // Saturating event counters; a clear request takes precedence over counting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q  <= '0;
            flush_cnt_q  <= '0;
            freeze_cnt_q <= '0;
        end else if (iPerfClr) begin
            stall_cnt_q  <= '0;
            flush_cnt_q  <= '0;
            freeze_cnt_q <= '0;
        end else begin
            if (oIDEX_Bubble && (stall_cnt_q != '1))
                stall_cnt_q <= stall_cnt_q + CNT_ONE;
            if (oIFID_Flush && (flush_cnt_q != '1))
                flush_cnt_q <= flush_cnt_q + CNT_ONE;
            if (oPipe_Freeze && (freeze_cnt_q != '1))
                freeze_cnt_q <= freeze_cnt_q + CNT_ONE;
        end
    end

    assign oStallCnt  = stall_cnt_q;
    assign oFlushCnt  = flush_cnt_q;
    assign oFreezeCnt = freeze_cnt_q;
`else
    logic unused_perf_clr;

    assign unused_perf_clr = iPerfClr;
    assign oStallCnt       = '0;
    assign oFlushCnt       = '0;
    assign oFreezeCnt      = '0;
`endif

endmodule
